load_store_unit: RTL

- MEM-stage block of the pipeline CPU, directly upstream of the 5-input 32-bit writeback select mux.
- Takes a load/store request from the EX/MEM pipeline register and runs a ready-handshake with data memory.
- Sign/zero-extends load data into the 32-bit LOAD_DATA word that drives the mux's memory-data input.
- Stalls the pipeline via BUSYWAIT while an access is outstanding.

---
 rtl/load_store_unit.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: ready-handshake with data memory, store lane steering and load extension.
// Optional access timeout is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ_EN,
  input  logic        WRITE_EN,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic        MEM_READY,
  input  logic [31:0] MEM_READDATA,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  output logic [3:0]  MEM_BYTEEN,
  output logic [31:0] LOAD_DATA,
  output logic        BUSYWAIT,
  output logic        ACCESS_FAULT,
  output logic        BUS_ERROR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_q;
  logic        memRead_q, memWrite_q, accessFault_q;
  logic [31:0] memAddr_q, memWdata_q, loadData_q;
  logic [3:0]  memByteen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offs_q;

  logic        request, reqFault;
  logic [31:0] storeData_d, loadData_d;
  logic [3:0]  storeByteen_d;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  assign request = READ_EN | WRITE_EN;

  always_comb begin
    reqFault = 1'b0;
    if (READ_EN && WRITE_EN)                              reqFault = 1'b1;
    if (FUNCT3 == 3'b011 || FUNCT3[2:1] == 2'b11)         reqFault = 1'b1;
    if (WRITE_EN && FUNCT3[2])                            reqFault = 1'b1;
    if (FUNCT3[1:0] == 2'b01 && ADDRESS[0])               reqFault = 1'b1;
    if (FUNCT3 == 3'b010 && ADDRESS[1:0] != 2'b00)        reqFault = 1'b1;
  end

  // Stores replicate the datum across lanes so memory only needs the byte enables.
  always_comb begin
    storeData_d   = WRITE_DATA;
    storeByteen_d = 4'b1111;
    case (FUNCT3[1:0])
      2'b00: begin
        storeData_d   = {4{WRITE_DATA[7:0]}};
        storeByteen_d = 4'b0001 << ADDRESS[1:0];
      end
      2'b01: begin
        storeData_d   = {2{WRITE_DATA[15:0]}};
        storeByteen_d = ADDRESS[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (offs_q)
      2'd0:    byteSel = MEM_READDATA[7:0];
      2'd1:    byteSel = MEM_READDATA[15:8];
      2'd2:    byteSel = MEM_READDATA[23:16];
      default: byteSel = MEM_READDATA[31:24];
    endcase
    halfSel = offs_q[1] ? MEM_READDATA[31:16] : MEM_READDATA[15:0];
    case (funct3_q)
      3'b000:  loadData_d = {{24{byteSel[7]}}, byteSel};
      3'b100:  loadData_d = {24'd0, byteSel};
      3'b001:  loadData_d = {{16{halfSel[15]}}, halfSel};
      3'b101:  loadData_d = {16'd0, halfSel};
      default: loadData_d = MEM_READDATA;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CntW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 :
                        (($clog2(TIMEOUT_CYCLES + 1) > 32) ? 32 : $clog2(TIMEOUT_CYCLES + 1));
  logic [CntW-1:0] cnt_q;
  logic            busError_q;
  assign BUS_ERROR = busError_q;
`else
  assign BUS_ERROR = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= IDLE;
      memRead_q     <= 1'b0;
      memWrite_q    <= 1'b0;
      memAddr_q     <= '0;
      memWdata_q    <= '0;
      memByteen_q   <= '0;
      loadData_q    <= '0;
      accessFault_q <= 1'b0;
      funct3_q      <= '0;
      offs_q        <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= '0;
      busError_q    <= 1'b0;
`endif
    end else begin
      accessFault_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      busError_q    <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (request && reqFault) begin
            accessFault_q <= 1'b1;
            state_q       <= DONE;
          end else if (request) begin
            memRead_q   <= READ_EN;
            memWrite_q  <= WRITE_EN;
            memAddr_q   <= {ADDRESS[31:2], 2'b00};
            memWdata_q  <= storeData_d;
            memByteen_q <= WRITE_EN ? storeByteen_d : 4'b0000;
            funct3_q    <= FUNCT3;
            offs_q      <= ADDRESS[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_q       <= '0;
`endif
            state_q     <= ACCESS;
          end
        end
        ACCESS: begin
          if (MEM_READY) begin
            if (memRead_q) loadData_q <= loadData_d;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            state_q    <= DONE;
          end
`ifdef LSU_TIMEOUT_EN
          else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            busError_q <= 1'b1;
            state_q    <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign MEM_READ      = memRead_q;
  assign MEM_WRITE     = memWrite_q;
  assign MEM_ADDRESS   = memAddr_q;
  assign MEM_WRITEDATA = memWdata_q;
  assign MEM_BYTEEN    = memByteen_q;
  assign LOAD_DATA     = loadData_q;
  assign ACCESS_FAULT  = accessFault_q;
  assign BUSYWAIT      = ((state_q == IDLE) && request) || (state_q == ACCESS);

endmodule
